sha_sigma_pipe: RTL and testbench
=================================

Name: sha_sigma_pipe

Overview:
Parametrised, pipelined bit-mixing unit for the SHA message-schedule and compression datapath. It replaces the fixed single-rotation wiring blocks. Per transaction it computes one of the four SHA Sigma/sigma functions, or a generic rotate-right or shift-right by a run-time amount. It uses a two-stage valid/ready pipeline with full backpressure and sits between the W-schedule buffer and the round adder tree.

Parameters:
- WIDTH, 32, word width; legal values 32 (SHA-256 constants) and 64 (SHA-512 constants); any other value is an elaboration error.
- TAG_W, 4, width of the opaque sideband tag carried alongside each word.
- AMT_W, $clog2(WIDTH), width of the run-time shift amount (derived; do not override).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input word valid.
- in_ready, output, 1, unit can accept an input this cycle.
- in_mode, input, 3, operation: 0 BSIG0, 1 BSIG1, 2 SSIG0, 3 SSIG1, 4 ROTR, 5 SHR, 6-7 illegal.
- in_amt, input, AMT_W, shift amount; used only by modes 4 and 5.
- in_data, input, WIDTH, operand.
- in_tag, input, TAG_W, sideband tag.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- out_data, output, WIDTH, result.
- out_tag, output, TAG_W, tag that arrived with the operand.
- out_err, output, 1, result came from an illegal mode.
- busy, output, 1, either pipeline stage holds a valid entry.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All valids, out_data, out_tag and out_err are 0; busy is 0 and in_ready is 1.
  - Reset asserted mid-operation discards all in-flight entries.
- Handshake:
  - A transfer occurs on a cycle where valid and ready are both 1.
  - Once out_valid is asserted, out_data, out_tag and out_err stay stable until out_ready is seen.
- Latency: a result appears exactly 2 cycles after acceptance when there is no stall. Throughput is 1 per cycle while out_ready=1.
- Stage 1 (s1):
  - Registers three WIDTH-bit terms t0, t1, t2, plus tag and err.
  - Constants for WIDTH=32: BSIG0 = ROTR2, ROTR13, ROTR22; BSIG1 = ROTR6, ROTR11, ROTR25; SSIG0 = ROTR7, ROTR18, SHR3; SSIG1 = ROTR17, ROTR19, SHR10.
  - Constants for WIDTH=64: BSIG0 = ROTR28, ROTR34, ROTR39; BSIG1 = ROTR14, ROTR18, ROTR41; SSIG0 = ROTR1, ROTR8, SHR7; SSIG1 = ROTR19, ROTR61, SHR6.
  - ROTR mode: t0 = ROTR(in_data, in_amt), t1 = t2 = 0.
  - SHR mode: t0 = in_data >> in_amt, zero-filled; t1 = t2 = 0.
  - in_amt = 0 returns the operand unchanged.
  - Illegal mode: t0 = t1 = t2 = 0 and err = 1.
- Stage 2 (s2): out_data = t0 ^ t1 ^ t2; tag and err pass through.
- Flow control:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
- Simultaneous accept on input and output with both stages full: both stages shift and no bubble is inserted.
- Stall: with out_ready=0 and both stages full, in_ready=0 and nothing moves.
- Rotations are pure bit permutations: rotation by k is taken mod WIDTH, with no arithmetic.

Decomposition:
- Package sha_sigma_pkg holds the mode enum (BSIG0..SHR, ILLEGAL), the rotation/shift constant tables for 32 and 64, and a function rotr(x, k).
- One sub-module, sha_rotr_var: a combinational log-depth barrel rotator/shifter (WIDTH, AMT_W, shr_mode input) used for modes 4 and 5. The fixed-constant modes use pure wiring.

Test Plan:
- WIDTH=32, BSIG0 on 0x6a09e667 -> 0xce20b47e two cycles later, tag echoed.
- WIDTH=32, BSIG1 on 0x510e527f -> 0x3587272b; SSIG0 on 0x00000001 -> 0x02004000; SSIG1 on 0x00000001 -> 0x0000a000.
- ROTR with 0x00000001, amt=1 -> 0x80000000; SHR with 0x80000000, amt=31 -> 0x00000001; ROTR with amt=0 -> operand unchanged.
- Mode 6 -> out_data=0, out_err=1; the following legal op has out_err=0.
- Backpressure:
  - Stream 8 back-to-back ops while holding out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, out_data stays stable.
  - On release, all 8 results emerge in order with no loss or duplication.
- Reset: assert rst_n=0 with both stages full -> out_valid=0, busy=0, in_ready=1 immediately (asynchronously); no stale result appears after release.
- Repeat the first and third scenarios with WIDTH=64 using the 64-bit constant table and a reference model.

Source files
------------

// File: rtl/sha_sigma_pkg.sv
// Shared definitions for the SHA Sigma/sigma mixing pipeline: operation codes,
// rotation/shift constant tables for both word sizes, and a fixed-rotate helper.
package sha_sigma_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        BSIG0   = 3'd0,
        BSIG1   = 3'd1,
        SSIG0   = 3'd2,
        SSIG1   = 3'd3,
        ROTR    = 3'd4,
        SHR     = 3'd5,
        ILLEGAL = 3'd6
    } mode_e;

    // Three amounts per function, ordered BSIG0, BSIG1, SSIG0, SSIG1; the third
    // entry of SSIG0/SSIG1 is a plain right shift, every other entry a rotation.
    localparam int unsigned SIG32_AMT [12] = '{2, 13, 22, 6, 11, 25, 7, 18, 3, 17, 19, 10};
    localparam int unsigned SIG64_AMT [12] = '{28, 34, 39, 14, 18, 41, 1, 8, 7, 19, 61, 6};

    function automatic int unsigned sig_amt(input int unsigned width, input int unsigned mode,
                                            input int unsigned idx);
        return (width == 64) ? SIG64_AMT[4'(mode * 3 + idx)] : SIG32_AMT[4'(mode * 3 + idx)];
    endfunction

    // Rotate right as a bit permutation of the low 'width' bits.
    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned k,
                                         input int unsigned width);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < width; i++) begin
            r[6'(i)] = x[6'((i + k) % width)];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha_sigma_pipe_if.sv
// Upstream/downstream valid-ready bundle of the Sigma pipeline. The master
// side is the producer/consumer pair around the unit; the slave is the unit.
interface sha_sigma_pipe_if
    import sha_sigma_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int AMT_W = $clog2(WIDTH)
);
    logic              in_valid;
    logic              in_ready;
    logic [MODE_W-1:0] in_mode;
    logic [AMT_W-1:0]  in_amt;
    logic [WIDTH-1:0]  in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    modport master (
        output in_valid, in_mode, in_amt, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_mode, in_amt, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/sha_rotr_var.sv
// Combinational log-depth barrel rotator / zero-fill right shifter for the
// run-time amount modes.
module sha_rotr_var #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    input  logic             shr_mode,
    output logic [WIDTH-1:0] result
);

    // Level s moves by 2**s when amt[s] is set; each level is its own signal
    // so the chain is not seen as a self-referencing array.
    for (genvar s = 0; s < AMT_W; s++) begin : g_lvl
        localparam int SH = 1 << s;
        logic [WIDTH-1:0] prev;
        logic [WIDTH-1:0] moved;
        logic [WIDTH-1:0] q;

        if (s == 0) begin : g_first
            assign prev = data;
        end else begin : g_next
            assign prev = g_lvl[s-1].q;
        end

        assign moved = shr_mode ? (prev >> SH) : {prev[SH-1:0], prev[WIDTH-1:SH]};
        assign q     = amt[s] ? moved : prev;
    end

    assign result = g_lvl[AMT_W-1].q;

endmodule

// File: rtl/sha_sigma_pipe.sv
// Two-stage valid/ready pipeline computing SHA Sigma/sigma functions or a
// run-time rotate/shift; stage 1 forms three terms, stage 2 XORs them.
module sha_sigma_pipe
    import sha_sigma_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha_sigma_pipe_if.slave      bus,
    output logic                 busy
);

    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $error("sha_sigma_pipe: WIDTH must be 32 or 64");
    end

    mode_e             mode;
    logic [WIDTH-1:0]  fix_t [4][3];
    logic [WIDTH-1:0]  var_res;
    logic [WIDTH-1:0]  t0_d, t1_d, t2_d;
    logic              err_d;

    logic              s1_valid;
    logic [WIDTH-1:0]  s1_t0, s1_t1, s1_t2;
    logic [TAG_W-1:0]  s1_tag;
    logic              s1_err;

    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic              out_err_q;

    logic              s1_adv, s2_adv;

    assign mode = mode_e'(bus.in_mode);

    // Fixed-constant terms are pure wiring of the operand.
    for (genvar m = 0; m < 4; m++) begin : g_fix_m
        for (genvar i = 0; i < 3; i++) begin : g_fix_i
            localparam int unsigned K = sig_amt(WIDTH, m, i);
            if (m >= 2 && i == 2) begin : g_shr
                assign fix_t[m][i] = bus.in_data >> K;
            end else begin : g_rot
                assign fix_t[m][i] = WIDTH'(rotr(64'(bus.in_data), K, WIDTH));
            end
        end
    end

    sha_rotr_var #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_rotr (
        .data     (bus.in_data),
        .amt      (bus.in_amt),
        .shr_mode (mode == SHR),
        .result   (var_res)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        t0_d  = '0;
        t1_d  = '0;
        t2_d  = '0;
        err_d = 1'b0;
        case (mode)
            BSIG0:     begin t0_d = fix_t[0][0]; t1_d = fix_t[0][1]; t2_d = fix_t[0][2]; end
            BSIG1:     begin t0_d = fix_t[1][0]; t1_d = fix_t[1][1]; t2_d = fix_t[1][2]; end
            SSIG0:     begin t0_d = fix_t[2][0]; t1_d = fix_t[2][1]; t2_d = fix_t[2][2]; end
            SSIG1:     begin t0_d = fix_t[3][0]; t1_d = fix_t[3][1]; t2_d = fix_t[3][2]; end
            ROTR, SHR: t0_d = var_res;
            default:   err_d = 1'b1;
        endcase
    end

    // Output regs only move when empty or drained, which holds them stable under stall.
    assign s2_adv       = !out_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            s1_valid <= 1'b0;
            s1_t0    <= '0;
            s1_t1    <= '0;
            s1_t2    <= '0;
            s1_tag   <= '0;
            s1_err   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_t0  <= t0_d;
                s1_t1  <= t1_d;
                s1_t2  <= t2_d;
                s1_tag <= bus.in_tag;
                s1_err <= err_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_data_q <= s1_t0 ^ s1_t1 ^ s1_t2;
                out_tag_q  <= s1_tag;
                out_err_q  <= s1_err;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_err   = out_err_q;
    assign busy          = s1_valid || out_valid_q;

endmodule

// File: tb/tb_sha_sigma_pipe.sv
// Bench for sha_sigma_pipe at WIDTH 32 and 64: directed vectors, stall/release,
// back-to-back streaming, async reset and random traffic against a shift/OR model.
module tb_sha_sigma_pipe;
    import sha_sigma_pkg::*;

    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy32, busy64;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sha_sigma_pipe_if #(.WIDTH(32), .TAG_W(TAG_W)) bus32 ();
    sha_sigma_pipe_if #(.WIDTH(64), .TAG_W(TAG_W)) bus64 ();

    sha_sigma_pipe #(.WIDTH(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32), .busy(busy32));
    sha_sigma_pipe #(.WIDTH(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .bus(bus64), .busy(busy64));

    localparam int K32 [12] = '{2, 13, 22, 6, 11, 25, 7, 18, 3, 17, 19, 10};
    localparam int K64 [12] = '{28, 34, 39, 14, 18, 41, 1, 8, 7, 19, 61, 6};

    // Reference model: rotations as shift/OR arithmetic on a 64-bit container.
    function automatic logic [63:0] mask_of(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] ref_rot(input logic [63:0] x, input int k, input int w);
        int kk = k % w;
        if (kk == 0) return x & mask_of(w);
        return ((x >> kk) | (x << (w - kk))) & mask_of(w);
    endfunction

    function automatic logic [64:0] ref_op(input int w, input int mode, input int amt,
                                           input logic [63:0] x);
        logic [63:0] xm = x & mask_of(w);
        logic [63:0] r;
        int k0, k1, k2;
        if (mode <= 3) begin
            k0 = (w == 64) ? K64[mode*3]   : K32[mode*3];
            k1 = (w == 64) ? K64[mode*3+1] : K32[mode*3+1];
            k2 = (w == 64) ? K64[mode*3+2] : K32[mode*3+2];
            r  = ref_rot(xm, k0, w) ^ ref_rot(xm, k1, w)
               ^ ((mode >= 2) ? (xm >> k2) : ref_rot(xm, k2, w));
            return {1'b0, r};
        end
        if (mode == 4) return {1'b0, ref_rot(xm, amt, w)};
        if (mode == 5) return {1'b0, xm >> amt};
        return {1'b1, 64'h0};
    endfunction

    task automatic drive(input int w, input logic v, input int mode, input int amt,
                         input logic [63:0] x, input logic [3:0] tag, input logic rdy);
        if (w == 32) begin
            bus32.in_valid = v;  bus32.in_mode = 3'(mode); bus32.in_amt = 5'(amt);
            bus32.in_data = x[31:0]; bus32.in_tag = tag; bus32.out_ready = rdy;
        end else begin
            bus64.in_valid = v;  bus64.in_mode = 3'(mode); bus64.in_amt = 6'(amt);
            bus64.in_data = x; bus64.in_tag = tag; bus64.out_ready = rdy;
        end
    endtask

    task automatic sample(input int w, output logic ir, output logic ov, output logic [63:0] od,
                          output logic [3:0] ot, output logic oe, output logic bz);
        if (w == 32) begin
            ir = bus32.in_ready; ov = bus32.out_valid; od = 64'(bus32.out_data);
            ot = bus32.out_tag;  oe = bus32.out_err;   bz = busy32;
        end else begin
            ir = bus64.in_ready; ov = bus64.out_valid; od = bus64.out_data;
            ot = bus64.out_tag;  oe = bus64.out_err;   bz = busy64;
        end
    endtask

    task automatic test_reset();
        logic ir, ov, oe, bz;
        logic [63:0] od;
        logic [3:0] ot;
        for (int w = 32; w <= 64; w += 32) begin
            sample(w, ir, ov, od, ot, oe, bz);
            checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid w%0d got %b exp 0", w, ov); end
            checks++; if (bz !== 1'b0) begin errors++; $display("FAIL reset_busy w%0d got %b exp 0", w, bz); end
            checks++; if (ir !== 1'b1) begin errors++; $display("FAIL reset_in_ready w%0d got %b exp 1", w, ir); end
            checks++; if (od !== 64'h0 || ot !== 4'h0 || oe !== 1'b0) begin
                errors++; $display("FAIL reset_outputs w%0d got data %h tag %h err %b exp 0", w, od, ot, oe);
            end
        end
    endtask

    // One isolated operation: accepted, absent after one cycle, present after two, then gone.
    task automatic run_single(input string name, input int w, input int mode, input int amt,
                              input logic [63:0] x, input logic [3:0] tag,
                              input logic [63:0] exp, input logic exp_err);
        logic ir, ov, oe, bz;
        logic [63:0] od;
        logic [3:0] ot;
        @(negedge clk); drive(w, 1'b1, mode, amt, x, tag, 1'b1);
        #1 sample(w, ir, ov, od, ot, oe, bz);
        checks++; if (ir !== 1'b1) begin errors++; $display("FAIL %s accept in_ready got %b exp 1", name, ir); end
        @(negedge clk); drive(w, 1'b0, 0, 0, 64'h0, 4'h0, 1'b1);
        #1 sample(w, ir, ov, od, ot, oe, bz);
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL %s early out_valid got %b exp 0", name, ov); end
        @(negedge clk); #1 sample(w, ir, ov, od, ot, oe, bz);
        checks++; if (ov !== 1'b1 || od !== exp || ot !== tag || oe !== exp_err) begin
            errors++;
            $display("FAIL %s result got v%b d%h t%h e%b exp v1 d%h t%h e%b", name, ov, od, ot, oe, exp, tag, exp_err);
        end
        @(negedge clk); #1 sample(w, ir, ov, od, ot, oe, bz);
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL %s duplicate out_valid got %b exp 0", name, ov); end
    endtask

    task automatic test_vectors32();
        run_single("bsig0_32", 32, 0, 0, 64'h6a09e667, 4'h5, 64'hce20b47e, 1'b0);
        run_single("bsig1_32", 32, 1, 0, 64'h510e527f, 4'h6, 64'h3587272b, 1'b0);
        run_single("ssig0_32", 32, 2, 0, 64'h00000001, 4'h7, 64'h02004000, 1'b0);
        run_single("ssig1_32", 32, 3, 0, 64'h00000001, 4'h8, 64'h0000a000, 1'b0);
        run_single("rotr1_32", 32, 4, 1, 64'h00000001, 4'h9, 64'h80000000, 1'b0);
        run_single("shr31_32", 32, 5, 31, 64'h80000000, 4'ha, 64'h00000001, 1'b0);
        run_single("rotr0_32", 32, 4, 0, 64'hdeadbeef, 4'hb, 64'hdeadbeef, 1'b0);
        run_single("shr0_32",  32, 5, 0, 64'h8badf00d, 4'hc, 64'h8badf00d, 1'b0);
    endtask

    task automatic test_illegal();
        run_single("mode6",      32, 6, 3, 64'hffffffff, 4'h1, 64'h0, 1'b1);
        run_single("after_ill",  32, 4, 4, 64'h00000010, 4'h2, 64'h00000001, 1'b0);
        run_single("mode7",      32, 7, 0, 64'h12345678, 4'h3, 64'h0, 1'b1);
    endtask

    // Continuous input with out_ready held high: one result per cycle, no bubbles.
    task automatic test_back_to_back();
        logic ir, ov, oe, bz;
        logic [63:0] od;
        logic [3:0] ot;
        logic [64:0] exp [16];
        int md [16];
        int am [16];
        logic [63:0] dt [16];
        for (int i = 0; i < 16; i++) begin
            md[i] = $urandom_range(5); am[i] = $urandom_range(31);
            dt[i] = 64'($urandom()); exp[i] = ref_op(32, md[i], am[i], dt[i]);
        end
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c < 16) drive(32, 1'b1, md[c], am[c], dt[c], 4'(c), 1'b1);
            else        drive(32, 1'b0, 0, 0, 64'h0, 4'h0, 1'b1);
            #1 sample(32, ir, ov, od, ot, oe, bz);
            if (c < 16) begin
                checks++; if (ir !== 1'b1) begin errors++; $display("FAIL b2b in_ready c%0d got %b exp 1", c, ir); end
            end
            if (c >= 2) begin
                checks++;
                if (ov !== 1'b1 || od !== exp[c-2][63:0] || ot !== 4'(c-2)) begin
                    errors++;
                    $display("FAIL b2b result c%0d got v%b d%h t%h exp v1 d%h t%h", c, ov, od, ot, exp[c-2][63:0], 4'(c-2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic ir, ov, oe, bz;
        logic [63:0] od, held;
        logic [3:0] ot;
        logic held_ok = 1'b0;
        logic [64:0] expq [$];
        logic [3:0] tagq [$];
        logic [64:0] e;
        logic [3:0] et;
        int md [8];
        int am [8];
        logic [63:0] dt [8];
        int sent = 0, got = 0, cyc = 0;
        logic v;
        for (int i = 0; i < 8; i++) begin
            md[i] = $urandom_range(5); am[i] = $urandom_range(31); dt[i] = 64'($urandom());
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); drive(32, 1'b1, md[sent], am[sent], dt[sent], 4'(sent), 1'b0);
            #1 sample(32, ir, ov, od, ot, oe, bz);
            if (ov === 1'b1) begin
                if (held_ok) begin
                    checks++; if (od !== held) begin errors++; $display("FAIL stall_stable c%0d got %h exp %h", c, od, held); end
                end
                held = od; held_ok = 1'b1;
            end
            if (ir === 1'b1) begin
                expq.push_back(ref_op(32, md[sent], am[sent], dt[sent])); tagq.push_back(4'(sent)); sent++;
            end
        end
        checks++; if (sent != 2) begin errors++; $display("FAIL stall_accepts got %0d exp 2", sent); end
        checks++; if (ir !== 1'b0 || ov !== 1'b1 || bz !== 1'b1) begin
            errors++; $display("FAIL stall_flags got ir%b ov%b busy%b exp ir0 ov1 busy1", ir, ov, bz);
        end
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            v = (sent < 8);
            drive(32, v, v ? md[sent] : 0, v ? am[sent] : 0, v ? dt[sent] : 64'h0, 4'(sent), 1'b1);
            #1 sample(32, ir, ov, od, ot, oe, bz);
            if (ov === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin errors++; $display("FAIL release_spurious got %h exp none", od); end
                else begin
                    e = expq.pop_front(); et = tagq.pop_front();
                    if (od !== e[63:0] || ot !== et) begin
                        errors++; $display("FAIL release_order got d%h t%h exp d%h t%h", od, ot, e[63:0], et);
                    end
                end
                got++;
            end
            if (v && ir === 1'b1) begin
                expq.push_back(ref_op(32, md[sent], am[sent], dt[sent])); tagq.push_back(4'(sent)); sent++;
            end
            cyc++;
        end
        checks++; if (got != 8) begin errors++; $display("FAIL release_count got %0d exp 8", got); end
        @(negedge clk); drive(32, 1'b0, 0, 0, 64'h0, 4'h0, 1'b1);
        #1 sample(32, ir, ov, od, ot, oe, bz);
        checks++; if (ov !== 1'b0 || bz !== 1'b0) begin errors++; $display("FAIL release_drain got ov%b busy%b exp 0 0", ov, bz); end
    endtask

    // Random ops (including illegal modes) with random valid and out_ready.
    task automatic run_stream(input int w, input int n, input int ready_pct);
        logic ir, ov, oe, bz;
        logic [63:0] od;
        logic [3:0] ot;
        logic [64:0] expq [$];
        logic [3:0] tagq [$];
        logic [64:0] e;
        logic [3:0] et;
        int sent = 0, got = 0, cyc = 0;
        int md = 0, am = 0;
        logic [63:0] dt = 64'h0;
        logic [3:0] tg = 4'h0;
        logic have = 1'b0, v, rdy;
        while (got < n && cyc < n * 20 + 50) begin
            @(negedge clk);
            if (!have && sent < n) begin
                md = $urandom_range(7); am = $urandom_range(w - 1);
                dt = {32'($urandom()), 32'($urandom())}; tg = 4'($urandom_range(15)); have = 1'b1;
            end
            rdy = ($urandom_range(99) < 32'(ready_pct));
            v   = have && ($urandom_range(3) != 0);
            drive(w, v, md, am, dt, tg, rdy);
            #1 sample(w, ir, ov, od, ot, oe, bz);
            if (ov === 1'b1 && rdy) begin
                checks++;
                if (expq.size() == 0) begin errors++; $display("FAIL rand%0d spurious got %h exp none", w, od); end
                else begin
                    e = expq.pop_front(); et = tagq.pop_front();
                    if (od !== e[63:0] || oe !== e[64] || ot !== et) begin
                        errors++;
                        $display("FAIL rand%0d result got d%h e%b t%h exp d%h e%b t%h", w, od, oe, ot, e[63:0], e[64], et);
                    end
                end
                got++;
            end
            if (v && ir === 1'b1) begin
                expq.push_back(ref_op(w, md, am, dt)); tagq.push_back(tg); sent++; have = 1'b0;
            end
            cyc++;
        end
        checks++; if (got != n) begin errors++; $display("FAIL rand%0d count got %0d exp %0d", w, got, n); end
        @(negedge clk); drive(w, 1'b0, 0, 0, 64'h0, 4'h0, 1'b1);
    endtask

    task automatic test_width64();
        logic [64:0] e;
        e = ref_op(64, 0, 0, 64'h6a09e667f3bcc908);
        run_single("bsig0_64", 64, 0, 0, 64'h6a09e667f3bcc908, 4'h1, e[63:0], 1'b0);
        e = ref_op(64, 1, 0, 64'h510e527fade682d1);
        run_single("bsig1_64", 64, 1, 0, 64'h510e527fade682d1, 4'h2, e[63:0], 1'b0);
        run_single("ssig0_64", 64, 2, 0, 64'h1, 4'h3, 64'h8100000000000000, 1'b0);
        run_single("rotr1_64", 64, 4, 1, 64'h1, 4'h4, 64'h8000000000000000, 1'b0);
        run_single("shr63_64", 64, 5, 63, 64'h8000000000000000, 4'h5, 64'h1, 1'b0);
        run_single("rotr0_64", 64, 4, 0, 64'h0123456789abcdef, 4'h6, 64'h0123456789abcdef, 1'b0);
        run_single("mode6_64", 64, 6, 0, 64'hffff, 4'h7, 64'h0, 1'b1);
        run_stream(64, 150, 70);
    endtask

    task automatic test_reset_midflight();
        logic ir, ov, oe, bz;
        logic [63:0] od;
        logic [3:0] ot;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(32, 1'b1, 0, 0, 64'h6a09e667, 4'hf, 1'b0);
            drive(64, 1'b1, 1, 0, 64'h510e527fade682d1, 4'he, 1'b0);
        end
        #1;
        for (int w = 32; w <= 64; w += 32) begin
            sample(w, ir, ov, od, ot, oe, bz);
            checks++; if (ov !== 1'b1 || ir !== 1'b0) begin
                errors++; $display("FAIL prereset_full w%0d got ov%b ir%b exp ov1 ir0", w, ov, ir);
            end
        end
        rst_n = 1'b0;
        #1;
        for (int w = 32; w <= 64; w += 32) begin
            sample(w, ir, ov, od, ot, oe, bz);
            checks++; if (ov !== 1'b0 || bz !== 1'b0 || ir !== 1'b1) begin
                errors++; $display("FAIL async_reset w%0d got ov%b busy%b ir%b exp 0 0 1", w, ov, bz, ir);
            end
        end
        drive(32, 1'b0, 0, 0, 64'h0, 4'h0, 1'b1);
        drive(64, 1'b0, 0, 0, 64'h0, 4'h0, 1'b1);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            for (int w = 32; w <= 64; w += 32) begin
                sample(w, ir, ov, od, ot, oe, bz);
                checks++; if (ov !== 1'b0 || bz !== 1'b0) begin
                    errors++; $display("FAIL stale_after_reset w%0d c%0d got ov%b busy%b exp 0 0", w, c, ov, bz);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        drive(32, 1'b0, 0, 0, 64'h0, 4'h0, 1'b1);
        drive(64, 1'b0, 0, 0, 64'h0, 4'h0, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_reset();
        test_vectors32();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        run_stream(32, 200, 60);
        test_width64();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
